// File: rtl/alu_issue_sequencer.sv
`default_nettype none
// =============================================================================
// alu_issue_sequencer : issues one instruction at a time to a combinational ALU
// (IDLE/READ/EXEC/WB) and writes the result back. ALU_SEQ_ZERO_REG_EN makes r0 zero.
// Revision: 1.0
// =============================================================================

package InstructionSetPkg;
  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_MOVE = 4'd1,
    OP_LIL  = 4'd2,
    OP_LIH  = 4'd3,
    OP_ADD  = 4'd4,
    OP_ADC  = 4'd5,
    OP_SUB  = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_XOR  = 4'd9,
    OP_NOT  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12
  } eOperation;

  typedef struct packed {
    logic Carry;
    logic Zero;
    logic Negative;
    logic Parity;
    logic Overflow;
  } sFlags;
endpackage

module alu_issue_sequencer
  import InstructionSetPkg::*;
#(
  parameter  int RegCount     = 8,
  localparam int RegAddrWidth = $clog2(RegCount)
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      InstrValid,
  output logic                      InstrReady,
  input  eOperation                 InstrOp,
  input  logic [RegAddrWidth-1:0]   InstrSrc,
  input  logic [RegAddrWidth-1:0]   InstrDest,
  input  logic [ImmediateWidth-1:0] InstrImm,
  output eOperation                 AluOperation,
  output sFlags                     AluInFlags,
  output logic [ImmediateWidth-1:0] AluInImm,
  output logic [DataWidth-1:0]      AluInSrc,
  output logic [DataWidth-1:0]      AluInDest,
  input  logic [DataWidth-1:0]      AluOutDest,
  input  sFlags                     AluOutFlags,
  output logic                      RetireValid,
  output logic [RegAddrWidth-1:0]   RetireDest,
  output logic [DataWidth-1:0]      RetireData,
  output sFlags                     Flags,
  input  logic [RegAddrWidth-1:0]   DbgAddr,
  output logic [DataWidth-1:0]      DbgData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      accept;
  logic                      wb_enable;

  eOperation                 op_latch;
  logic [RegAddrWidth-1:0]   src_latch;
  logic [RegAddrWidth-1:0]   dest_latch;
  logic [ImmediateWidth-1:0] imm_latch;

  logic [DataWidth-1:0]      regs [RegCount];
  logic [DataWidth-1:0]      result_data;
  sFlags                     result_flags;

  function automatic logic [DataWidth-1:0] reg_read(input logic [RegAddrWidth-1:0] addr);
    logic [DataWidth-1:0] value;
    value = regs[addr];
`ifdef ALU_SEQ_ZERO_REG_EN
    if (addr == '0) value = '0;
`endif
    return value;
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    InstrReady  = 1'b0;
    RetireValid = 1'b0;
    case (state)
      IDLE: begin
        InstrReady = nReset;
        if (InstrValid && nReset) state_next = READ;
      end
      READ: state_next = EXEC;
      EXEC: state_next = WB;
      WB: begin
        RetireValid = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = InstrValid && InstrReady;

  // ---------------------------------------------------------------------------
  // Instruction latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      op_latch   <= eOperation'('0);
      src_latch  <= '0;
      dest_latch <= '0;
      imm_latch  <= '0;
    end else if (accept) begin
      op_latch   <= InstrOp;
      src_latch  <= InstrSrc;
      dest_latch <= InstrDest;
      imm_latch  <= InstrImm;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU operand registers: loaded in READ, held until the next READ
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      AluOperation <= eOperation'('0);
      AluInImm     <= '0;
      AluInSrc     <= '0;
      AluInDest    <= '0;
      AluInFlags   <= '0;
    end else if (state == READ) begin
      AluOperation <= op_latch;
      AluInImm     <= imm_latch;
      AluInSrc     <= reg_read(src_latch);
      AluInDest    <= reg_read(dest_latch);
      AluInFlags   <= Flags;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      result_data  <= '0;
      result_flags <= '0;
    end else if (state == EXEC) begin
      result_data  <= AluOutDest;
      result_flags <= AluOutFlags;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback: the only write path into the register file and flags
  // ---------------------------------------------------------------------------
`ifdef ALU_SEQ_ZERO_REG_EN
  assign wb_enable = (state == WB) && (dest_latch != '0);
`else
  assign wb_enable = (state == WB);
`endif

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int i = 0; i < RegCount; i++) regs[i] <= '0;
    end else if (wb_enable) begin
      regs[dest_latch] <= result_data;
    end
  end

  // Flags update on WB even when the data write to r0 is discarded.
  always_ff @(posedge Clock) begin
    if (!nReset)            Flags <= '0;
    else if (state == WB)   Flags <= result_flags;
  end

  assign RetireDest = dest_latch;
  assign RetireData = result_data;
  assign DbgData    = reg_read(DbgAddr);

  a_retire_single_pulse : assert property (
    @(posedge Clock) disable iff (!nReset) RetireValid |=> !RetireValid
  );

endmodule

`default_nettype wire
